voice_mixer: RTL
================

# voice_mixer

- Parametrised N-voice output stage for the DDS core; sits between the voice generators and the DAC/output pins.
- Snapshots all voice samples on a sample tick, then walks them sequentially through a single adder.
- Produces one registered output sample per tick in one of three modes:
  - select one voice,
  - averaged mix,
  - saturating sum.
- A per-voice mute mask applies to the mix modes.

## Interface
Parameters:
- `M`, 12, sample width in bits (unsigned, offset-binary samples).
- `N`, 4, voice count; power of two, 2..16.
- `SELW`, 2, select width; equals clog2(N).

Ports:
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_bus`  in  N*M  flattened voices; voice k is bits [k*M+M-1 : k*M].
- `sample_tick`  in  1  one-cycle strobe requesting a new output sample.
- `mode`  in  2  00 select, 01 average, 10 saturating sum, 11 reserved (behaves as 00).
- `sel`  in  SELW  voice index used in select mode.
- `mute`  in  N  bit k=1 excludes voice k from modes 01/10; ignored in select mode.
- `out`  out  M  mixed sample, held between updates.
- `out_valid`  out  1  one-cycle pulse when `out` updates.
- `busy`  out  1  high while a sample is in progress.
- `overrun`  out  1  sticky dropped-tick flag; present only with `VOICE_MIXER_OVERRUN_EN`.

## Operation
- FSM states: IDLE, ACC, DONE. Reset state is IDLE.
- **IDLE**
  - When `sample_tick` is high, latch `in_bus`, `mode`, `sel` and `mute` into a snapshot.
  - Clear the accumulator and the index counter, then go to ACC.
  - Live inputs are ignored until the next accepted tick.
- **ACC**
  - Each cycle, add snapshot voice[idx] to the accumulator if the voice is unmuted; otherwise add 0.
  - Then idx++.
  - After idx N-1 has been added, go to DONE.
- **DONE**
  - Load `out` from the result, pulse `out_valid`, return to IDLE.
- Accumulator width is M+SELW bits, zero-extended, and can never overflow.
- Result by mode:
  - Select: snapshot voice[sel]. The accumulator is still stepped, so latency is identical in every mode.
  - Average: acc >> SELW (truncating). Muted voices count as 0; the divisor stays N.
  - Saturating sum: if acc > 2^M-1 then all ones, else acc[M-1:0].
  - All voices muted in modes 01/10: `out` = 0, `out_valid` still pulses.
- `busy` is high in ACC and DONE and low in IDLE.
- A `sample_tick` seen in ACC or DONE is dropped: no restart, and the snapshot is unchanged.
- Async reset mid-operation:
  - Returns to IDLE with `out`=0, `out_valid`=0, `busy`=0, `overrun`=0.
  - No pulse is emitted for the aborted sample.

## Timing
- Reset values: `out`=0, `out_valid`=0, `busy`=0, `overrun`=0, accumulator 0, idx 0.
- Let E0 be the rising edge that samples `sample_tick`=1 in IDLE.
  - Edges E1..EN add voices 0..N-1.
  - Edge EN+1 registers `out` and sets `out_valid`.
  - `out_valid` clears at EN+2.
- Latency from tick to valid output: N+1 clocks.
- `busy` rises at E0 and falls at EN+1.
- A tick sampled at EN+1 (state DONE) is dropped. Minimum accepted tick spacing is N+2 clocks.
- `out` changes only at the DONE edge; all outputs are registered.

## Configuration
- `VOICE_MIXER_OVERRUN_EN` defined:
  - `overrun` port exists.
  - It sets at the edge that samples a dropped tick (ACC or DONE).
  - It stays set until `rst_n` is asserted.
- Not defined:
  - Port and flag logic are absent.
  - Dropped ticks are silently ignored; all other behaviour is identical.

## Test plan
- Reset with `rst_n` low mid-ACC, N=4, M=12 -> all outputs 0 immediately; no `out_valid` after release; next tick works normally.
- Mode 00, voices {0x111,0x222,0x333,0x444}, `sel`=2, tick -> `out`=0x333, `out_valid` one cycle at E5, `busy` high E0..E4.
- Mode 01, voices {0x100,0x200,0x300,0x400}, `mute`=0000 -> `out`=0x280. Same with `mute`=1000 -> `out`=0x180.
- Mode 10, all voices 0x600 -> `out`=0xFFF. Voices {0x001,0x002,0,0} -> 0x003. `mute`=1111 -> 0x000 with `out_valid` pulsing.
- Snapshot isolation: change `in_bus` and `mode` at E2 -> result reflects values latched at E0.
- Second tick at E3 and at E5 -> both dropped, one `out_valid` only, `overrun`=1 with the macro defined. Tick at E6 -> accepted, valid at E11.

Source files
------------

// File: rtl/voice_mixer.sv
// voice_mixer: N-voice output stage. Snapshots all voices on a sample tick,
// walks them through one adder, and registers one output sample per tick in
// select, average or saturating-sum mode.
// Optional build macro VOICE_MIXER_OVERRUN_EN adds a sticky dropped-tick flag.
module voice_mixer #(
    parameter int unsigned M    = 12,
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*M-1:0]    in_bus,
    input  logic              sample_tick,
    input  logic [1:0]        mode,
    input  logic [SELW-1:0]   sel,
    input  logic [N-1:0]      mute,
    output logic [M-1:0]      out,
    output logic              out_valid,
    output logic              busy
`ifdef VOICE_MIXER_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    localparam int unsigned AW = M + SELW;
    localparam logic [1:0] MODE_AVG = 2'b01;
    localparam logic [1:0] MODE_SAT = 2'b10;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

    state_e            state_q, state_d;
    logic [N*M-1:0]    snap_bus_q, snap_bus_d;
    logic [1:0]        snap_mode_q, snap_mode_d;
    logic [SELW-1:0]   snap_sel_q, snap_sel_d;
    logic [N-1:0]      snap_mute_q, snap_mute_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [SELW-1:0]   idx_q, idx_d;
    logic [M-1:0]      out_q, out_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [M-1:0]      voice_c;
    logic [M-1:0]      sel_voice_c;
    logic [M-1:0]      result_c;
`ifdef VOICE_MIXER_OVERRUN_EN
    logic              overrun_q, overrun_d;
`endif

    // Snapshot voice at the walk index, the selected voice, and the mode result
    always_comb begin
        voice_c     = snap_bus_q[32'(idx_q) * M +: M];
        sel_voice_c = snap_bus_q[32'(snap_sel_q) * M +: M];
        case (snap_mode_q)
            MODE_AVG: result_c = M'(acc_q >> SELW);
            MODE_SAT: result_c = (|acc_q[AW-1:M]) ? {M{1'b1}} : acc_q[M-1:0];
            default:  result_c = sel_voice_c;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        snap_bus_d  = snap_bus_q;
        snap_mode_d = snap_mode_q;
        snap_sel_d  = snap_sel_q;
        snap_mute_d = snap_mute_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_d       = out_q;
        valid_d     = 1'b0;
`ifdef VOICE_MIXER_OVERRUN_EN
        overrun_d   = overrun_q | (sample_tick && (state_q != IDLE));
`endif
        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    snap_bus_d  = in_bus;
                    snap_mode_d = mode;
                    snap_sel_d  = sel;
                    snap_mute_d = mute;
                    acc_d       = '0;
                    idx_d       = '0;
                    state_d     = ACC;
                end
            end
            ACC: begin
                // Muted voices contribute zero; stepping continues in every mode
                acc_d = acc_q + (snap_mute_q[idx_q] ? AW'(0) : AW'(voice_c));
                idx_d = SELW'(idx_q + 1'b1);
                if (idx_q == SELW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_d   = result_c;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            snap_bus_q  <= '0;
            snap_mode_q <= '0;
            snap_sel_q  <= '0;
            snap_mute_q <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_bus_q  <= snap_bus_d;
            snap_mode_q <= snap_mode_d;
            snap_sel_q  <= snap_sel_d;
            snap_mute_q <= snap_mute_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef VOICE_MIXER_OVERRUN_EN
    // Sticky dropped-tick flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;

endmodule
